// File: rtl/nand_buf_pkg.sv
// Shared sizing helpers and parameter bounds for the NAND page-buffer bank logic.
package nand_buf_pkg;

  localparam int NUM_BANKS_MIN   = 2;
  localparam int NUM_BANKS_MAX   = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a bank index; never narrower than one bit.
  function automatic int bank_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return clog2(n + 1);
  endfunction

endpackage

// File: rtl/nand_edge_sync.sv
// Synchroniser plus rising-edge detector for an asynchronous level input.
// Flops reset to 1 so a level already high when reset releases is not seen
// as a fresh edge.
module nand_edge_sync
  import nand_buf_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;

  // Shift the async level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_rise = r_sync[STAGES-2] & ~r_sync[STAGES-1];

endmodule

// File: rtl/nand_bank_rotator.sv
// N-bank ring buffer rotation manager between the host page-buffer writer and
// the NAND programming engine. Tracks producer and consumer bank pointers,
// the number of full banks, a single pending rotation and sticky error flags.
module nand_bank_rotator
  import nand_buf_pkg::*;
#(
  parameter int  NUM_BANKS   = 2,
  parameter int  SYNC_STAGES = 2,
  localparam int BW          = bank_w(NUM_BANKS),
  localparam int CW          = cnt_w(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_done,
  input  logic          wr_busy,
  input  logic          rd_release,
  output logic [BW-1:0] wr_bank,
  output logic [BW-1:0] rd_bank,
  output logic          rd_valid,
  output logic          full,
  output logic [CW-1:0] fill_count,
  output logic          wr_change,
  output logic          err_overrun,
  output logic          err_underflow
);

  if (NUM_BANKS < NUM_BANKS_MIN || NUM_BANKS > NUM_BANKS_MAX) begin : g_bad_banks
    $error("NUM_BANKS out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end

  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_BANKS - 1);

  // Ring increment; explicit wrap so non-power-of-2 bank counts work.
  function automatic logic [BW-1:0] inc_mod(input logic [BW-1:0] p);
    return (p == LAST_BANK) ? '0 : p + BW'(1);
  endfunction

  logic [BW-1:0] r_wr_bank;
  logic [BW-1:0] r_rd_bank;
  logic [CW-1:0] r_fill;
  logic          r_pend;
  logic          r_rd_valid;
  logic          r_full;
  logic          r_wr_change;
  logic          r_err_overrun;
  logic          r_err_underflow;

  logic          w_req;
  logic          w_fill_nz;
  logic          w_rel_ok;
  logic          w_can_rot;
  logic          w_rot;
  logic [CW-1:0] w_fill_nxt;

  nand_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_wr_done_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (wr_done),
    .o_rise  (w_req)
  );

  assign w_fill_nz = (r_fill != '0);
  assign w_rel_ok  = rd_release && w_fill_nz;
  // A same-cycle release frees a bank, so a full ring can still rotate.
  assign w_can_rot = !wr_busy && ((r_fill < FULL_CNT) || w_rel_ok);
  assign w_rot     = (w_req || r_pend) && w_can_rot;

  // Next fill count: rotation adds a full bank, release removes one.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_rot && !w_rel_ok) begin
      w_fill_nxt = r_fill + CW'(1);
    end else if (!w_rot && w_rel_ok) begin
      w_fill_nxt = r_fill - CW'(1);
    end
  end

  // Pointers, fill accounting, status flags and the wr_change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank   <= '0;
      r_rd_bank   <= '0;
      r_fill      <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_wr_change <= 1'b0;
    end else begin
      if (w_rot) begin
        r_wr_bank <= inc_mod(r_wr_bank);
      end
      if (w_rel_ok) begin
        r_rd_bank <= inc_mod(r_rd_bank);
      end
      r_fill      <= w_fill_nxt;
      r_rd_valid  <= (w_fill_nxt != '0);
      r_full      <= (w_fill_nxt == FULL_CNT);
      r_wr_change <= w_rot;
    end
  end

  // Single pending-rotation slot; a second request while it is occupied is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (w_rot) begin
      r_pend <= 1'b0;
    end else if (w_req && !r_pend) begin
      r_pend <= 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_overrun   <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_req && r_pend) begin
        r_err_overrun <= 1'b1;
      end
      if (rd_release && !w_fill_nz) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign wr_bank       = r_wr_bank;
  assign rd_bank       = r_rd_bank;
  assign fill_count    = r_fill;
  assign rd_valid      = r_rd_valid;
  assign full          = r_full;
  assign wr_change     = r_wr_change;
  assign err_overrun   = r_err_overrun;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_nand_bank_rotator.sv
// Scoreboard bench for nand_bank_rotator: a 4-bank instance exercises
// rotation, deferral, overrun, underflow and async reset; a 3-bank instance
// exercises non-power-of-2 wrap.
module tb_nand_bank_rotator;

  typedef struct {
    int wr;
    int rd;
    int fill;
    int full;
    int valid;
  } snap_t;

  logic clk = 1'b0;
  logic rst;

  logic       a_wr_done, a_wr_busy, a_rd_release;
  logic [1:0] a_wr_bank, a_rd_bank;
  logic [2:0] a_fill;
  logic       a_rd_valid, a_full, a_wr_change, a_err_o, a_err_u;

  logic       b_wr_done, b_wr_busy, b_rd_release;
  logic [1:0] b_wr_bank, b_rd_bank;
  logic [1:0] b_fill;
  logic       b_rd_valid, b_full, b_wr_change, b_err_o, b_err_u;

  int    n_checks = 0;
  int    n_errors = 0;
  snap_t qa[$];
  snap_t qb[$];

  int exp_wr_b[5] = '{1, 2, 0, 1, 2};
  int exp_rd_b[5] = '{0, 1, 2, 0, 1};

  nand_bank_rotator #(.NUM_BANKS(4), .SYNC_STAGES(2)) dut_a (
    .clk (clk), .rst (rst), .wr_done (a_wr_done), .wr_busy (a_wr_busy),
    .rd_release (a_rd_release), .wr_bank (a_wr_bank), .rd_bank (a_rd_bank),
    .rd_valid (a_rd_valid), .full (a_full), .fill_count (a_fill),
    .wr_change (a_wr_change), .err_overrun (a_err_o), .err_underflow (a_err_u)
  );

  nand_bank_rotator #(.NUM_BANKS(3), .SYNC_STAGES(2)) dut_b (
    .clk (clk), .rst (rst), .wr_done (b_wr_done), .wr_busy (b_wr_busy),
    .rd_release (b_rd_release), .wr_bank (b_wr_bank), .rd_bank (b_rd_bank),
    .rd_valid (b_rd_valid), .full (b_full), .fill_count (b_fill),
    .wr_change (b_wr_change), .err_overrun (b_err_o), .err_underflow (b_err_u)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic snap_t mk(input int wr, input int rd, input int fill,
                               input int fl, input int vl);
    snap_t s;
    s.wr = wr; s.rd = rd; s.fill = fill; s.full = fl; s.valid = vl;
    return s;
  endfunction

  task automatic cmp_snap(input string name, input snap_t a, input snap_t e);
    n_checks++;
    if (a.wr != e.wr || a.rd != e.rd || a.fill != e.fill ||
        a.full != e.full || a.valid != e.valid) begin
      n_errors++;
      $display("FAIL %s: got wr=%0d rd=%0d fill=%0d full=%0d valid=%0d, expected wr=%0d rd=%0d fill=%0d full=%0d valid=%0d",
               name, a.wr, a.rd, a.fill, a.full, a.valid,
               e.wr, e.rd, e.fill, e.full, e.valid);
    end
  endtask

  // Monitor for instance A: every wr_change pulse must match the next queued snapshot.
  always @(negedge clk) begin
    if (!rst && a_wr_change) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_wr_change: got unexpected pulse wr=%0d, expected none", a_wr_bank);
      end else begin
        cmp_snap("a_rotation", mk(a_wr_bank, a_rd_bank, a_fill, a_full, a_rd_valid),
                 qa.pop_front());
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst && b_wr_change) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_wr_change: got unexpected pulse wr=%0d, expected none", b_wr_bank);
      end else begin
        cmp_snap("b_rotation", mk(b_wr_bank, b_rd_bank, b_fill, b_full, b_rd_valid),
                 qb.pop_front());
      end
    end
  end

  task automatic pulse_a();
    a_wr_done = 1'b1;
    ticks(3);
    a_wr_done = 1'b0;
    ticks(3);
  endtask

  task automatic rel_a();
    a_rd_release = 1'b1;
    tick();
    a_rd_release = 1'b0;
  endtask

  task automatic pulse_b();
    b_wr_done = 1'b1;
    ticks(3);
    b_wr_done = 1'b0;
    ticks(3);
  endtask

  task automatic rel_b();
    b_rd_release = 1'b1;
    tick();
    b_rd_release = 1'b0;
  endtask

  initial begin
    a_wr_done = 0; a_wr_busy = 0; a_rd_release = 0;
    b_wr_done = 0; b_wr_busy = 0; b_rd_release = 0;
    rst = 1'b1;
    ticks(3);
    check("reset_wr_bank", a_wr_bank, 0);
    check("reset_fill", a_fill, 0);
    check("reset_rd_valid", a_rd_valid, 0);
    rst = 1'b0;
    ticks(3);

    // First rotation: latency of one edge after the sampling edge.
    qa.push_back(mk(1, 0, 1, 0, 1));
    a_wr_done = 1'b1;
    tick();
    check("lat_wr_before", a_wr_bank, 0);
    tick();
    check("lat_wr_after", a_wr_bank, 1);
    check("lat_wr_change_hi", a_wr_change, 1);
    tick();
    check("lat_wr_change_lo", a_wr_change, 0);
    a_wr_done = 1'b0;
    ticks(3);

    // Deferral while wr_busy is high.
    qa.push_back(mk(2, 0, 2, 0, 1));
    a_wr_busy = 1'b1;
    a_wr_done = 1'b1;
    ticks(5);
    check("defer_wr_hold", a_wr_bank, 1);
    a_wr_busy = 1'b0;
    tick();
    check("defer_wr_exec", a_wr_bank, 2);
    check("defer_no_overrun", a_err_o, 0);
    a_wr_done = 1'b0;
    ticks(3);

    // Fill to full, pend a fourth request, release frees it in the same edge.
    qa.push_back(mk(3, 0, 3, 1, 1));
    pulse_a();
    check("full_set", a_full, 1);
    pulse_a();
    check("full_pend_wr", a_wr_bank, 3);
    qa.push_back(mk(0, 1, 3, 1, 1));
    rel_a();
    check("relrot_rd", a_rd_bank, 1);
    check("relrot_wr", a_wr_bank, 0);
    check("relrot_fill", a_fill, 3);
    ticks(2);

    // Overrun: second request while one is pending; only one rotation follows.
    pulse_a();
    check("overrun_clear", a_err_o, 0);
    pulse_a();
    check("overrun_set", a_err_o, 1);
    qa.push_back(mk(1, 2, 3, 1, 1));
    rel_a();
    check("overrun_rot_wr", a_wr_bank, 1);
    rel_a();
    ticks(2);
    check("single_rot_wr", a_wr_bank, 1);
    check("single_rot_rd", a_rd_bank, 3);
    check("single_rot_fill", a_fill, 2);
    check("single_rot_full", a_full, 0);

    // Drain and underflow.
    rel_a();
    rel_a();
    check("drain_rd", a_rd_bank, 1);
    check("drain_valid", a_rd_valid, 0);
    check("underflow_clear", a_err_u, 0);
    rel_a();
    check("underflow_set", a_err_u, 1);
    check("underflow_rd", a_rd_bank, 1);
    check("underflow_fill", a_fill, 0);
    check("underflow_wr", a_wr_bank, 1);

    // Async reset mid-deferral with fill_count=2 and a pending request.
    qa.push_back(mk(2, 1, 1, 0, 1));
    pulse_a();
    qa.push_back(mk(3, 1, 2, 0, 1));
    pulse_a();
    a_wr_busy = 1'b1;
    a_wr_done = 1'b1;
    ticks(3);
    check("predefer_fill", a_fill, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("areset_wr", a_wr_bank, 0);
    check("areset_rd", a_rd_bank, 0);
    check("areset_fill", a_fill, 0);
    check("areset_full", a_full, 0);
    check("areset_err_o", a_err_o, 0);
    check("areset_err_u", a_err_u, 0);
    a_wr_busy = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(4);
    check("held_level_wr", a_wr_bank, 0);
    check("held_level_fill", a_fill, 0);
    a_wr_done = 1'b0;
    ticks(3);
    qa.push_back(mk(1, 0, 1, 0, 1));
    a_wr_done = 1'b1;
    ticks(2);
    check("post_reset_rot", a_wr_bank, 1);
    a_wr_done = 1'b0;
    ticks(3);

    // Three-bank wrap through five rotate/release pairs.
    for (int i = 0; i < 5; i++) begin
      qb.push_back(mk(exp_wr_b[i], exp_rd_b[i], 1, 0, 1));
      pulse_b();
      check("b_wr_seq", b_wr_bank, exp_wr_b[i]);
      rel_b();
      check("b_rd_seq", b_rd_bank, exp_wr_b[i]);
      check("b_fill_seq", b_fill, 0);
    end
    ticks(3);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
